// File: rtl/fp32_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_seq
// Brief    : Multi-cycle FP32 multiplier (shift-add significand, truncating,
//            denormals flushed to zero) with valid/ready on both sides.
// Revision : 1.0
// ============================================================================

module fp32_mul_seq #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [31:0] CANON_NAN      = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output logic        busy
);

    localparam int         c_MUL_CYCLES = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] c_LAST_COUNT = 5'(c_MUL_CYCLES - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CLASSIFY = 3'd1;
    localparam logic [2:0] c_MUL      = 3'd2;
    localparam logic [2:0] c_NORM     = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    logic [2:0]        r_state, w_state_next;
    logic [31:0]       r_a, r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [47:0]       r_acc;
    logic [47:0]       r_ma_sh;
    logic [23:0]       r_mb_sh;
    logic [4:0]        r_count;
    logic [31:0]       r_result;
    logic [2:0]        r_flags;

    logic [7:0]        w_ea, w_eb;
    logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic              w_sign, w_special;
    logic signed [9:0] w_exp_sum;
    logic [31:0]       w_spec_result;
    logic [2:0]        w_spec_flags;
    logic [47:0]       w_acc_sum;
    logic signed [9:0] w_norm_exp;
    logic [22:0]       w_norm_mant;
    logic [31:0]       w_norm_result;
    logic [2:0]        w_norm_flags;

    // Operand decode; a zero exponent field covers both zero and denormal.
    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_zero_a  = (w_ea == 8'h00);
    assign w_zero_b  = (w_eb == 8'h00);
    assign w_inf_a   = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_inf_b   = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_nan_a   = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_nan_b   = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_sign    = r_a[31] ^ r_b[31];
    assign w_special = w_zero_a | w_zero_b | w_inf_a | w_inf_b | w_nan_a | w_nan_b;
    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

    always_comb begin
        w_spec_result = {w_sign, 31'd0};
        w_spec_flags  = 3'b000;
        if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
            w_spec_result = CANON_NAN;
            w_spec_flags  = 3'b100;
        end else if (w_inf_a || w_inf_b) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
        end
    end

    // Consume the low BITS_PER_CYCLE multiplier bits against the pre-shifted multiplicand.
    always_comb begin
        w_acc_sum = r_acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mb_sh[j]) begin
                w_acc_sum = w_acc_sum + (r_ma_sh << j);
            end
        end
    end

    assign w_norm_exp  = r_acc[47] ? (r_exp + 10'sd1) : r_exp;
    assign w_norm_mant = r_acc[47] ? r_acc[46:24] : r_acc[45:23];

    always_comb begin
        w_norm_result = {r_sign, w_norm_exp[7:0], w_norm_mant};
        w_norm_flags  = 3'b000;
        if (w_norm_exp >= 10'sd255) begin
            w_norm_result = {r_sign, 8'hFF, 23'd0};
            w_norm_flags  = 3'b010;
        end else if (w_norm_exp <= 10'sd0) begin
            w_norm_result = {r_sign, 31'd0};
            w_norm_flags  = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:     if (in_valid) w_state_next = c_CLASSIFY;
            c_CLASSIFY: w_state_next = w_special ? c_DONE : c_MUL;
            c_MUL:      if (r_count == c_LAST_COUNT) w_state_next = c_NORM;
            c_NORM:     w_state_next = c_DONE;
            c_DONE:     if (out_ready) w_state_next = c_IDLE;
            default:    w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_acc    <= 48'd0;
            r_ma_sh  <= 48'd0;
            r_mb_sh  <= 24'd0;
            r_count  <= 5'd0;
            r_result <= 32'd0;
            r_flags  <= 3'b000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a <= in_a;
                        r_b <= in_b;
                    end
                end
                c_CLASSIFY: begin
                    r_sign  <= w_sign;
                    r_exp   <= w_exp_sum;
                    r_acc   <= 48'd0;
                    r_count <= 5'd0;
                    r_ma_sh <= {24'd0, 1'b1, r_a[22:0]};
                    r_mb_sh <= {1'b1, r_b[22:0]};
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_flags  <= w_spec_flags;
                    end
                end
                c_MUL: begin
                    r_acc   <= w_acc_sum;
                    r_ma_sh <= r_ma_sh << BITS_PER_CYCLE;
                    r_mb_sh <= r_mb_sh >> BITS_PER_CYCLE;
                    r_count <= r_count + 5'd1;
                end
                c_NORM: begin
                    r_result <= w_norm_result;
                    r_flags  <= w_norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == c_IDLE);
    assign out_valid  = (r_state == c_DONE);
    assign busy       = (r_state != c_IDLE);
    assign out_result = r_result;
    assign out_flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fp32_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_seq
// Brief    : Self-checking bench for fp32_mul_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================

module tb_fp32_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp32_mul_seq #(
        .BITS_PER_CYCLE(1),
        .CANON_NAN     (32'h7FC0_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact 48-bit significand product, then truncate and range-check.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [2:0] fl,
                                    output int lat);
        int          ea, eb, e;
        bit          za, zb, ia, ib, na, nb, s;
        logic [47:0] p;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        fl  = 3'b000;
        lat = 2;
        if (na || nb || (ia && zb) || (za && ib)) begin
            res = 32'h7FC0_0000;
            fl  = 3'b100;
        end else if (ia || ib) begin
            res = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            res = {s, 31'd0};
        end else begin
            lat = 27;
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = ea + eb - 127;
            if (p[47]) begin
                e++;
                res = {s, 8'(e), p[46:24]};
            end else begin
                res = {s, 8'(e), p[45:23]};
            end
            if (e >= 255) begin
                res = {s, 8'hFF, 23'd0};
                fl  = 3'b010;
            end else if (e <= 0) begin
                res = {s, 31'd0};
                fl  = 3'b001;
            end
        end
    endfunction

    // Accept one operand pair, measure latency, check result, then consume it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [2:0] exp_fl, input int lat);
        int n;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_fl));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, r;
        logic [2:0]  fl;
        int          lat;
        int          n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);

        run_op("one_x_two", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 3'b000, 27);
        run_op("sign",      32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 3'b000, 27);
        run_op("carry",     32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 27);
        run_op("inf_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 2);
        run_op("neg_inf",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 2);
        run_op("denorm",    32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000, 2);
        run_op("nan",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 2);
        run_op("overflow",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b010, 27);
        run_op("underflow", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b001, 27);
        run_op("neg_uflow", 32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, 3'b001, 27);

        // Backpressure: result must hold and a second request must be ignored.
        in_a     = 32'h3F80_0000;
        in_b     = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 32'(n), 32'd27);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h4040_0000;
            in_b     = 32'h4040_0000;
            @(negedge clk);
            check("bp_result", out_result, 32'h4000_0000);
            check("bp_hold", {29'd0, out_flags}, 32'd0);
            check("bp_ready_valid", {30'd0, in_ready, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);

        // Reset while the multiply is at counter 10.
        in_a     = 32'h3FC0_0000;
        in_b     = 32'h3FC0_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("mid_rst_result", out_result, 32'd0);
        run_op("after_rst", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 3'b000, 27);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(64, 190));
            if ($urandom_range(0, 3) != 0) b[30:23] = 8'($urandom_range(64, 190));
            if ($urandom_range(0, 9) == 0) a[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 9) == 0) b[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            ref_mul(a, b, r, fl, lat);
            run_op("rand", a, b, r, fl, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Multi-cycle FP32 multiplier sequencer for the shader ALU.
- Classifies both operands with the FP32 decoder (zero/denorm/inf/nan).
- Resolves special cases immediately; otherwise runs a shift-add mantissa multiply over several cycles, then normalises.
- Uses a valid/ready handshake on both input and output, so it can sit behind an issue arbiter and in front of a writeback FIFO.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits of the 24-bit significand consumed per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8 and 12. MUL_CYCLES = 24 / BITS_PER_CYCLE.
- CANON_NAN, 32'h7FC00000: value emitted for every NaN result.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: high only in IDLE.
- in_a, input, 32: multiplicand, IEEE-754 binary32.
- in_b, input, 32: multiplier, IEEE-754 binary32.
- out_valid, output, 1: result valid; held until consumed.
- out_ready, input, 1: consumer accepts the result.
- out_result, output, 32: product.
- out_flags, output, 3: {invalid, overflow, underflow}. Valid with out_valid.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (synchronous, any state, including mid-multiply): after the edge, state = IDLE, in_ready = 1, out_valid = 0, out_result = 0, out_flags = 0, busy = 0, accumulator cleared. An in-flight operation is dropped silently.
- States: IDLE, CLASSIFY, MUL, NORM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register in_a and in_b, then go to CLASSIFY.
- CLASSIFY (1 cycle): decode both registered operands. Denormals are flushed to zero (treated as zero, sign kept). sign_r = sa ^ sb.
  - Special cases, in priority order (all go to DONE):
    - Either operand NaN: result CANON_NAN, invalid = 1.
    - Inf times zero (either order): result CANON_NAN, invalid = 1.
    - Either operand inf: result {sign_r, 8'hFF, 23'h0}.
    - Either operand zero: result {sign_r, 31'h0}.
  - Otherwise:
    - exp = ea + eb - 127, 10-bit signed.
    - ma = {1, mant_a}, mb = {1, mant_b}.
    - acc = 0, counter = 0.
    - Go to MUL.
- MUL (MUL_CYCLES cycles):
  - Each cycle, for each of BITS_PER_CYCLE bits j: if mb[counter*BITS_PER_CYCLE + j] is set, add ma << (counter*BITS_PER_CYCLE + j) to acc.
  - acc is 48 bits unsigned.
  - Increment counter; at counter == MUL_CYCLES-1, go to NORM.
- NORM (1 cycle):
  - If acc[47] = 1: mant = acc[46:24] and exp = exp + 1. Else mant = acc[45:23].
  - Truncate (round toward zero); no inexact flag.
  - If exp >= 255: result {sign_r, 8'hFF, 0}, overflow = 1.
  - If exp <= 0: result {sign_r, 31'h0}, underflow = 1 (flush to zero).
  - Otherwise: result {sign_r, exp[7:0], mant}.
  - Go to DONE.
- DONE:
  - out_valid = 1; out_result and out_flags are stable.
  - On out_ready: out_valid drops after the edge and state returns to IDLE.
  - No new operand is accepted in the same cycle (in_ready = 0 in DONE).
- Latency, from the accepting edge to out_valid high:
  - Special case: 2 cycles.
  - Normal: 2 + MUL_CYCLES + 1 cycles (27 for BITS_PER_CYCLE = 1; 6 for 8).
- Throughput: one operation per latency + 1 cycles when out_ready is held high.
- out_ready asserted outside DONE has no effect.
- in_valid outside IDLE is ignored; inputs are not required to stay stable after acceptance.

Test Plan:
- Basic multiply: 3F800000 × 40000000 (1.0 × 2.0) → out_result 40000000, flags 000, out_valid exactly 27 cycles after accept (BITS_PER_CYCLE = 1).
- Normalisation carry and sign: 3FC00000 × C0000000 (1.5 × -2.0) → C0400000. Also 3FC00000 × 3FC00000 → 40100000 (takes the acc[47] path).
- Specials, each → out_valid 2 cycles after accept:
  - 7F800000 × 00000000 → 7FC00000, invalid = 1.
  - FF800000 × 40000000 → FF800000.
  - 00000001 (denorm) × 3F800000 → 00000000.
  - 7FC00001 × 3F800000 → 7FC00000, invalid = 1.
- Range limits:
  - 7F000000 × 40000000 → 7F800000, overflow = 1.
  - 00800000 × 3F000000 → 00000000, underflow = 1.
  - 80800000 × 3F000000 → 80000000, underflow = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → result and flags stable, in_ready = 0, a second in_valid is not accepted. Raising out_ready → in_ready = 1 in the following cycle.
- Reset mid-MUL: assert reset at MUL cycle 10 for one cycle → next cycle in_ready = 1, out_valid = 0, busy = 0. A fresh 40400000 × 40400000 (3.0 × 3.0) → 41100000 with correct latency, showing no stale accumulator contents.
